// File: rtl/rv32_pipeline_sequencer.sv
// rv32_pipeline_sequencer: stall/flush scheduler and FENCE drain FSM
// for the five-stage RV32 pipeline.
//
// Ports:
//   clk, reset (async, active-high)
//   decode: decode_valid_in, rs1/rs2_unreg_in, rs1/rs2_read_unreg_in,
//           mem_fence_unreg_in
//   older stages: execute_valid_in, mem_valid_in, execute_mem_read_in,
//                 execute_rd_in, execute_rd_write_in, mem_busy_in
//   redirects: branch_mispredicted_in, trap_in
//   controls: *_stall_out, *_flush_out, fence_busy_out
//   RV32_SEQ_PERF_EN: stall_cycles_out, flush_events_out
//
// Event priority: trap > memory wait > mispredict > fence > load-use.
// While reset is high all flushes are forced high and stalls low.
module rv32_pipeline_sequencer #(
  parameter int PERF_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       decode_valid_in,
  input  logic [4:0] rs1_unreg_in,
  input  logic [4:0] rs2_unreg_in,
  input  logic       rs1_read_unreg_in,
  input  logic       rs2_read_unreg_in,
  input  logic       mem_fence_unreg_in,
  input  logic       execute_valid_in,
  input  logic       mem_valid_in,
  input  logic       execute_mem_read_in,
  input  logic [4:0] execute_rd_in,
  input  logic       execute_rd_write_in,
  input  logic       mem_busy_in,
  input  logic       branch_mispredicted_in,
  input  logic       trap_in,
  output logic       fetch_stall_out,
  output logic       decode_stall_out,
  output logic       execute_stall_out,
  output logic       mem_stall_out,
  output logic       fetch_flush_out,
  output logic       decode_flush_out,
  output logic       execute_flush_out,
  output logic       writeback_flush_out,
  output logic       fence_busy_out
`ifdef RV32_SEQ_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0] stall_cycles_out,
  output logic [PERF_WIDTH-1:0] flush_events_out
`endif
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       in_run;
  logic       older_busy;
  logic       fence_start;
  logic       rs1_hit;
  logic       rs2_hit;
  logic       load_use;

  assign in_run     = (state == S_RUN);
  assign older_busy = execute_valid_in | mem_valid_in;

  assign fence_start = in_run & decode_valid_in
                     & mem_fence_unreg_in;

  assign rs1_hit = rs1_read_unreg_in
                 & (rs1_unreg_in == execute_rd_in);
  assign rs2_hit = rs2_read_unreg_in
                 & (rs2_unreg_in == execute_rd_in);

  assign load_use = execute_mem_read_in
                  & execute_rd_write_in
                  & (execute_rd_in != 5'd0)
                  & (rs1_hit | rs2_hit);

  always_comb begin
    fetch_stall_out     = 1'b0;
    decode_stall_out    = 1'b0;
    execute_stall_out   = 1'b0;
    mem_stall_out       = 1'b0;
    fetch_flush_out     = 1'b0;
    decode_flush_out    = 1'b0;
    execute_flush_out   = 1'b0;
    writeback_flush_out = 1'b0;
    state_nxt           = S_RUN;
    if (reset || trap_in) begin
      fetch_flush_out     = 1'b1;
      decode_flush_out    = 1'b1;
      execute_flush_out   = 1'b1;
      writeback_flush_out = 1'b1;
    end else if (mem_busy_in) begin
      // whole pipe waits; writeback gets a bubble
      fetch_stall_out     = 1'b1;
      decode_stall_out    = 1'b1;
      execute_stall_out   = 1'b1;
      mem_stall_out       = 1'b1;
      writeback_flush_out = 1'b1;
      state_nxt           = state;
    end else if (branch_mispredicted_in) begin
      // also kills a draining fence
      decode_flush_out  = 1'b1;
      execute_flush_out = 1'b1;
    end else if (state == S_DRAIN) begin
      fetch_stall_out   = 1'b1;
      decode_stall_out  = 1'b1;
      execute_flush_out = 1'b1;
      state_nxt = older_busy ? S_DRAIN : S_RELEASE;
    end else if (state == S_RELEASE) begin
      // fence leaves decode; drop prefetched work
      fetch_flush_out = 1'b1;
    end else if (fence_start) begin
      // hold the fence in decode from its first cycle
      fetch_stall_out   = 1'b1;
      decode_stall_out  = 1'b1;
      execute_flush_out = 1'b1;
      state_nxt = older_busy ? S_DRAIN : S_RELEASE;
    end else if (load_use && in_run) begin
      fetch_stall_out   = 1'b1;
      decode_stall_out  = 1'b1;
      execute_flush_out = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  assign fence_busy_out = ~in_run;

`ifdef RV32_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_out <= '0;
      flush_events_out <= '0;
    end else begin
      if (decode_stall_out)
        stall_cycles_out <= stall_cycles_out
                          + PERF_WIDTH'(1);
      if (branch_mispredicted_in || trap_in)
        flush_events_out <= flush_events_out
                          + PERF_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rv32_pipeline_sequencer.sv
// tb_rv32_pipeline_sequencer: directed + random check of the
// sequencer against a behavioural model of its scheduling rules.
module tb_rv32_pipeline_sequencer;

`ifdef RV32_SEQ_PERF_EN
  localparam int PW = 3;
`else
  localparam int PW = 32;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic decode_valid, rs1_read, rs2_read, fence;
  logic [4:0] rs1, rs2, execute_rd;
  logic execute_valid, mem_valid, execute_mem_read;
  logic execute_rd_write, mem_busy, mispred, trap;
  logic fs, ds, es, ms, ff, df, ef, wf, busy;
`ifdef RV32_SEQ_PERF_EN
  logic [PW-1:0] stall_cycles, flush_events;
  logic [PW-1:0] m_stalls = '0;
  logic [PW-1:0] m_flushes = '0;
`endif

  int tests = 0;
  int fails = 0;
  int ph = 0;
  logic chk_en = 1'b1;

  rv32_pipeline_sequencer #(.PERF_WIDTH(PW)) dut (
    .clk(clk),
    .reset(reset),
    .decode_valid_in(decode_valid),
    .rs1_unreg_in(rs1),
    .rs2_unreg_in(rs2),
    .rs1_read_unreg_in(rs1_read),
    .rs2_read_unreg_in(rs2_read),
    .mem_fence_unreg_in(fence),
    .execute_valid_in(execute_valid),
    .mem_valid_in(mem_valid),
    .execute_mem_read_in(execute_mem_read),
    .execute_rd_in(execute_rd),
    .execute_rd_write_in(execute_rd_write),
    .mem_busy_in(mem_busy),
    .branch_mispredicted_in(mispred),
    .trap_in(trap),
    .fetch_stall_out(fs),
    .decode_stall_out(ds),
    .execute_stall_out(es),
    .mem_stall_out(ms),
    .fetch_flush_out(ff),
    .decode_flush_out(df),
    .execute_flush_out(ef),
    .writeback_flush_out(wf),
    .fence_busy_out(busy)
`ifdef RV32_SEQ_PERF_EN
    ,
    .stall_cycles_out(stall_cycles),
    .flush_events_out(flush_events)
`endif
  );

  always #5 clk = ~clk;

  // {fs,ds,es,ms, ff,df,ef,wf, busy}
  wire [8:0] dut_vec = {fs, ds, es, ms, ff, df, ef, wf, busy};

  // Phase: 0 = normal, 1 = waiting for older stages, 2 = release.
  function automatic logic [8:0] model_out(input int p);
    logic b, lu;
    b  = (p != 0);
    lu = execute_mem_read && execute_rd_write
      && execute_rd != 0
      && ((rs1_read && rs1 == execute_rd)
       || (rs2_read && rs2 == execute_rd));
    if (reset)        return 9'b0000_1111_0;
    if (trap)         return {8'b0000_1111, b};
    if (mem_busy)     return {8'b1111_0001, b};
    if (mispred)      return {8'b0000_0110, b};
    if (p == 1 || (p == 0 && decode_valid && fence))
      return {8'b1100_0010, b};
    if (p == 2)       return {8'b0000_1000, b};
    if (lu)           return {8'b1100_0010, b};
    return {8'b0, b};
  endfunction

  function automatic int model_next(input int p);
    if (trap)     return 0;
    if (mem_busy) return p;
    if (mispred)  return 0;
    if (p == 1)   return (execute_valid || mem_valid) ? 1 : 2;
    if (p == 2)   return 0;
    if (decode_valid && fence)
      return (execute_valid || mem_valid) ? 1 : 2;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [8:0] e;
    if (reset) begin
      ph = 0;
`ifdef RV32_SEQ_PERF_EN
      m_stalls  = '0;
      m_flushes = '0;
`endif
    end else begin
      e = model_out(ph);
`ifdef RV32_SEQ_PERF_EN
      if (e[7]) m_stalls = m_stalls + 1'b1;
      if (mispred || trap) m_flushes = m_flushes + 1'b1;
`endif
      ph = model_next(ph);
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (chk_en) begin
      e = model_out(ph);
      tests++;
      if (dut_vec !== e) begin
        fails++;
        $display("FAIL model t=%0t: dut=%b expected=%b",
                 $time, dut_vec, e);
      end
`ifdef RV32_SEQ_PERF_EN
      tests++;
      if (stall_cycles !== m_stalls
          || flush_events !== m_flushes) begin
        fails++;
        $display("FAIL perf_model t=%0t: dut=%0d/%0d expected=%0d/%0d",
                 $time, stall_cycles, flush_events,
                 m_stalls, m_flushes);
      end
`endif
    end
  end

  task automatic clr();
    decode_valid = 0; rs1_read = 0; rs2_read = 0; fence = 0;
    rs1 = 0; rs2 = 0; execute_rd = 0;
    execute_valid = 0; mem_valid = 0; execute_mem_read = 0;
    execute_rd_write = 0; mem_busy = 0; mispred = 0; trap = 0;
  endtask

  task automatic step(input logic [8:0] exp, input string nm);
    @(negedge clk);
    tests++;
    if (dut_vec !== exp) begin
      fails++;
      $display("FAIL %s: dut=%b expected=%b", nm, dut_vec, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_x5();
    execute_valid = 1; execute_mem_read = 1;
    execute_rd_write = 1; execute_rd = 5;
    decode_valid = 1; rs2 = 5; rs2_read = 1;
  endtask

  task automatic fence_in(input logic ev);
    decode_valid = 1; fence = 1; execute_valid = ev;
  endtask

`ifdef RV32_SEQ_PERF_EN
  task automatic chk_cnt(input logic [PW-1:0] got,
                         input logic [PW-1:0] exp,
                         input string nm);
    @(negedge clk);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: dut=%0d expected=%0d", nm, got, exp);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    clr();
    step(9'b0000_1111_0, "reset_0");
    step(9'b0000_1111_0, "reset_1");
    reset = 0;

    // load-use on rs2 = x5: one stall cycle, then clear
    load_x5();
    step(9'b1100_0010_0, "load_use");
    clr(); decode_valid = 1; rs2 = 5; rs2_read = 1;
    step(9'b0000_0000_0, "load_use_after");
    load_x5(); execute_rd = 0; rs2 = 0;
    step(9'b0000_0000_0, "load_use_x0");
    clr();

    // memory wait for 3 cycles
    mem_busy = 1;
    step(9'b1111_0001_0, "mem_wait_0");
    step(9'b1111_0001_0, "mem_wait_1");
    step(9'b1111_0001_0, "mem_wait_2");
    mem_busy = 0;
    step(9'b0000_0000_0, "mem_wait_end");

    // fence drain with execute busy for 2 cycles
    fence_in(1);
    step(9'b1100_0010_0, "fence_detect");
    step(9'b1100_0010_1, "fence_drain_0");
    execute_valid = 0;
    step(9'b1100_0010_1, "fence_drain_1");
    step(9'b0000_1000_1, "fence_release");
    clr();
    step(9'b0000_0000_0, "fence_run");

    // fence with empty pipe goes straight to release
    fence_in(0);
    step(9'b1100_0010_0, "fence_direct");
    step(9'b0000_1000_1, "fence_direct_rel");
    clr();
    step(9'b0000_0000_0, "fence_direct_run");

    // trap during drain
    fence_in(1);
    step(9'b1100_0010_0, "trap_fence_det");
    step(9'b1100_0010_1, "trap_fence_drain");
    trap = 1;
    step(9'b0000_1111_1, "trap_in_drain");
    clr();
    step(9'b0000_0000_0, "trap_run");

    // mispredict during drain
    fence_in(1);
    step(9'b1100_0010_0, "misp_fence_det");
    step(9'b1100_0010_1, "misp_fence_drain");
    mispred = 1;
    step(9'b0000_0110_1, "misp_in_drain");
    clr();
    step(9'b0000_0000_0, "misp_run");

    // mem wait masks mispredict and load-use
    load_x5(); mem_busy = 1; mispred = 1;
    step(9'b1111_0001_0, "prio_mem");
    clr(); mispred = 1;
    step(9'b0000_0110_0, "prio_misp_after");
    clr();
    step(9'b0000_0000_0, "prio_idle");

    // async reset in the middle of a drain
    fence_in(1);
    step(9'b1100_0010_0, "rst_fence_det");
    step(9'b1100_0010_1, "rst_fence_drain");
    #2 reset = 1;
    step(9'b0000_1111_0, "rst_mid_drain");
    reset = 0; clr();
    step(9'b0000_0000_0, "rst_run");

`ifdef RV32_SEQ_PERF_EN
    reset = 1;
    step(9'b0000_1111_0, "perf_reset");
    reset = 0;
    mem_busy = 1;
    repeat (5) step(9'b1111_0001_0, "perf_stall");
    mem_busy = 0;
    chk_cnt(stall_cycles, 3'd5, "stall_cycles_5");
    mem_busy = 1;
    repeat (3) step(9'b1111_0001_0, "perf_stall_wrap");
    mem_busy = 0;
    chk_cnt(stall_cycles, 3'd0, "stall_cycles_wrap");
    mispred = 1; trap = 1;
    step(9'b0000_1111_0, "perf_both");
    clr();
    chk_cnt(flush_events, 3'd1, "flush_events_1");
`endif

    // random phase, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      decode_valid = ($urandom_range(0, 3) != 0);
      fence = ($urandom_range(0, 5) == 0);
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rs1_read = $urandom_range(0, 1);
      rs2_read = $urandom_range(0, 1);
      execute_valid = ($urandom_range(0, 2) != 0);
      mem_valid = ($urandom_range(0, 2) == 0);
      execute_mem_read = $urandom_range(0, 1);
      execute_rd_write = $urandom_range(0, 1);
      execute_rd = 5'($urandom_range(0, 3));
      mem_busy = ($urandom_range(0, 5) == 0);
      mispred = ($urandom_range(0, 15) == 0);
      trap = ($urandom_range(0, 31) == 0);
      @(posedge clk);
      #1;
    end
    reset = 0;
    clr();
    @(negedge clk);
    chk_en = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32_pipeline_sequencer.md
# rv32_pipeline_sequencer

Central stall/flush scheduler for the five-stage RV32 pipeline (fetch, decode, execute, mem, writeback). It takes the unregistered hazard information the decode stage exports, the execute/mem valid and load state, the data-memory busy handshake and the redirect/trap requests. It drives the per-stage `stall_in`/`flush_in` controls, including decode's `stall_in`, `flush_in` and `writeback_flush_in`. It also owns the FENCE/FENCE.I drain sequence, which is the block's only multi-cycle state machine.

## Interface
- `PERF_WIDTH`, default 32, width of the optional performance counters.
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-high reset.
- `decode_valid_in` in 1: decode holds a valid instruction.
- `rs1_unreg_in` / `rs2_unreg_in` in 5: decode source register indices.
- `rs1_read_unreg_in` / `rs2_read_unreg_in` in 1: the source register is actually read.
- `mem_fence_unreg_in` in 1: decode holds a FENCE/FENCE.I.
- `execute_valid_in` / `mem_valid_in` in 1: the older stage holds a valid instruction.
- `execute_mem_read_in` in 1: execute holds a load.
- `execute_rd_in` in 5: execute destination register.
- `execute_rd_write_in` in 1: execute writes its destination register.
- `mem_busy_in` in 1: data memory transaction not yet acknowledged.
- `branch_mispredicted_in` in 1: execute redirect.
- `trap_in` in 1: writeback trap/mret redirect.
- `fetch_stall_out`, `decode_stall_out`, `execute_stall_out`, `mem_stall_out` out 1: per-stage stalls.
- `fetch_flush_out`, `decode_flush_out`, `execute_flush_out`, `writeback_flush_out` out 1: per-stage flushes.
- `fence_busy_out` out 1: FSM is not in RUN.
- `stall_cycles_out` out `PERF_WIDTH`: cycles with `decode_stall_out` high. Present only with `RV32_SEQ_PERF_EN`.
- `flush_events_out` out `PERF_WIDTH`: count of mispredicts plus traps. Present only with `RV32_SEQ_PERF_EN`.

## Operation
- FSM states: RUN, DRAIN, RELEASE. Outputs are combinational from the inputs and the registered state.
- **Load-use**: active when `execute_mem_read_in && execute_rd_write_in && execute_rd_in != 0` and rsN matches `execute_rd_in` with its `rsN_read_unreg_in` set, for rs1 or rs2.
  - Asserts `fetch_stall_out` and `decode_stall_out`.
  - Asserts `execute_flush_out` to inject a bubble.
- **Memory wait** (`mem_busy_in`):
  - Stalls fetch, decode, execute and mem.
  - Asserts `writeback_flush_out` to inject a bubble into writeback.
- **Mispredict**: `decode_flush_out` and `execute_flush_out` kill the two younger instructions. Fetch is redirected externally.
- **Trap**:
  - All four flushes are high and all stalls are low.
  - The FSM is forced to RUN next cycle, aborting any DRAIN or RELEASE.
- **Fence**:
  - RUN→DRAIN when `decode_valid_in && mem_fence_unreg_in && (execute_valid_in || mem_valid_in)`, with no higher-priority event.
  - In DRAIN: fetch and decode stall, and `execute_flush_out` fills the pipeline with bubbles.
  - DRAIN→RELEASE once `execute_valid_in`, `mem_valid_in` and `mem_busy_in` are all 0.
  - In RELEASE: the fence leaves decode (no stall) and `fetch_flush_out` discards prefetched instructions. RELEASE→RUN unconditionally.
  - A fence seen in RUN with execute and mem already empty goes directly to RELEASE.
- **Priority**: trap > memory wait > mispredict > fence FSM > load-use. A lower-priority event is masked for that cycle.
  - Memory wait in DRAIN or RELEASE freezes the state.
  - Mispredict in DRAIN returns to RUN, because the fence itself is flushed.

## Timing
- **Reset values** (while `reset` is high):
  - State RUN.
  - All stalls 0.
  - All flushes 1.
  - `fence_busy_out` 0.
  - Counters 0.
- Load-use costs exactly one cycle. The bubble clears the match on the next cycle.
- The memory-wait stall lasts exactly as long as `mem_busy_in`. The release cycle has no stall.
- The fence costs (cycles until execute/mem are empty) + 1 RELEASE cycle.
- A reset asserted mid-DRAIN returns the FSM to RUN asynchronously.
- `fence_busy_out` is high in DRAIN and RELEASE.

## Configuration
- `RV32_SEQ_PERF_EN` defined: `stall_cycles_out` and `flush_events_out` exist.
  - Both increment on the clock edge and wrap modulo 2^`PERF_WIDTH`.
  - A simultaneous mispredict and trap counts as 1 event.
- `RV32_SEQ_PERF_EN` undefined: the ports and counters are absent. All other behaviour is unchanged.

## Test plan
- **Load-use**: load x5 in execute, decode reads rs2=x5 with `rs2_read_unreg_in`=1 → one cycle of fetch/decode stall plus `execute_flush_out`, then no stall. With rd=x0 → no stall.
- **Memory wait**: `mem_busy_in` held 3 cycles → fetch/decode/execute/mem stall for exactly 3 cycles, `writeback_flush_out` high for those 3 cycles.
- **Fence drain**: fence in decode, `execute_valid_in`=1 for 2 cycles → DRAIN for 2 cycles, then RELEASE with `fetch_flush_out`=1 for 1 cycle, then RUN.
- **Fence interrupted**:
  - Trap during DRAIN → all flushes high and RUN next cycle.
  - Mispredict during DRAIN → decode/execute flush and RUN next cycle.
- **Priority**: `mem_busy_in`, mispredict and load-use in the same cycle → only the memory-wait pattern appears. The mispredict is applied in the first cycle after `mem_busy_in` drops.
- **Reset/perf**: async reset mid-DRAIN → RUN with all flushes high. With `RV32_SEQ_PERF_EN`, 5 stall cycles → `stall_cycles_out`=5; counter preset near the top → wraps to 0.
